// File: rtl/mem_responder.sv
// Multi-channel valid/ready memory responder with a fixed, parameterised access latency.
// Each channel runs IDLE -> BUSY -> RESPOND -> DRAIN; the shared word array is never reset.
module mem_responder #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned NUM_CHANNELS  = 2,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned LATENCY       = 2,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CHANNELS-1:0]               mem_read_valid,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]               mem_read_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_read_data,
  input  logic [NUM_CHANNELS-1:0]               mem_write_valid,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_write_data,
  output logic [NUM_CHANNELS-1:0]               mem_write_ready,
  input  logic                                  load_valid,
  input  logic [ADDRESS_WIDTH-1:0]              load_address,
  input  logic [DATA_WIDTH-1:0]                 load_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CMP_W = ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND, DRAIN} state_e;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [NUM_CHANNELS-1:0]  wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]    wr_data [NUM_CHANNELS];

  // Extra compare bit so DEPTH == 2**ADDRESS_WIDTH still works.
  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
    return CMP_W'(a) < CMP_W'(DEPTH);
  endfunction

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    state_e                   state_q, state_d;
    logic                     op_wr_q, op_wr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     rready_q, rready_d;
    logic                     wready_q, wready_d;
    logic                     rd_valid, wr_valid;
    logic [DATA_WIDTH-1:0]    rd_word;

    assign rd_valid = mem_read_valid[i];
    assign wr_valid = mem_write_valid[i];
    assign rd_word  = in_range(addr_q) ? mem[addr_q[IDX_W-1:0]] : '0;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= IDLE;
        op_wr_q  <= 1'b0;
        cnt_q    <= '0;
        addr_q   <= '0;
        wdata_q  <= '0;
        rdata_q  <= '0;
        rready_q <= 1'b0;
        wready_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        op_wr_q  <= op_wr_d;
        cnt_q    <= cnt_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rdata_q  <= rdata_d;
        rready_q <= rready_d;
        wready_q <= wready_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      op_wr_d  = op_wr_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rready_d = 1'b0;
      wready_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rd_valid) begin
            addr_d  = mem_read_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            op_wr_d = 1'b0;
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = BUSY;
          end else if (wr_valid && (WRITE_ENABLE != 0)) begin
            addr_d  = mem_write_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            wdata_d = mem_write_data[i*DATA_WIDTH +: DATA_WIDTH];
            op_wr_d = 1'b1;
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = RESPOND;
            if (op_wr_q) begin
              wready_d = 1'b1;
            end else begin
              rdata_d  = rd_word;
              rready_d = 1'b1;
            end
          end
        end
        RESPOND: state_d = DRAIN;
        // Hold off until the initiator drops the request we just served.
        DRAIN: begin
          if (!(op_wr_q ? wr_valid : rd_valid)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    assign wr_en[i]   = (state_q == BUSY) && (cnt_q == '0) && op_wr_q;
    assign wr_addr[i] = addr_q;
    assign wr_data[i] = wdata_q;

    assign mem_read_ready[i]                          = rready_q;
    assign mem_write_ready[i]                         = wready_q;
    assign mem_read_data[i*DATA_WIDTH +: DATA_WIDTH]  = rdata_q;
  end

  // Later assignments win: channel writes override the backdoor, higher channels override lower.
  always_ff @(posedge clk) begin
    if (load_valid && in_range(load_address)) begin
      mem[load_address[IDX_W-1:0]] <= load_data;
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (wr_en[i] && in_range(wr_addr[i])) begin
        mem[wr_addr[i][IDX_W-1:0]] <= wr_data[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: drivers queue spec-level events, a negedge
// reference model turns them into expected responses, and a monitor checks every pulse.
module tb_mem_responder;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int NC    = 2;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          rv [NC];
  logic          wv [NC];
  logic [AW-1:0] ra [NC];
  logic [AW-1:0] wa [NC];
  logic [DW-1:0] wd [NC];
  logic          load_valid;
  logic [AW-1:0] load_address;
  logic [DW-1:0] load_data;

  logic [NC-1:0]    rv_bus, wv_bus, rr_bus, wr_bus;
  logic [NC*AW-1:0] ra_bus, wa_bus;
  logic [NC*DW-1:0] wd_bus, rd_bus;

  assign rv_bus = {rv[1], rv[0]};
  assign wv_bus = {wv[1], wv[0]};
  assign ra_bus = {ra[1], ra[0]};
  assign wa_bus = {wa[1], wa[0]};
  assign wd_bus = {wd[1], wd[0]};

  mem_responder #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CHANNELS(NC), .DEPTH(DEPTH),
                  .LATENCY(LAT), .WRITE_ENABLE(1)) u_dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv_bus), .mem_read_address(ra_bus),
    .mem_read_ready(rr_bus), .mem_read_data(rd_bus),
    .mem_write_valid(wv_bus), .mem_write_address(wa_bus), .mem_write_data(wd_bus),
    .mem_write_ready(wr_bus),
    .load_valid(load_valid), .load_address(load_address), .load_data(load_data)
  );

  // Read-only instance: DEPTH 16, LATENCY 1, writes disabled.
  logic [1:0]    ro_rv, ro_wv, ro_rr, ro_wr;
  logic [2*AW-1:0] ro_ra, ro_wa;
  logic [2*DW-1:0] ro_wd, ro_rd;
  logic          ro_load_valid;
  logic [AW-1:0] ro_load_address;
  logic [DW-1:0] ro_load_data;

  mem_responder #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CHANNELS(2), .DEPTH(16),
                  .LATENCY(1), .WRITE_ENABLE(0)) u_ro (
    .clk(clk), .reset(reset),
    .mem_read_valid(ro_rv), .mem_read_address(ro_ra),
    .mem_read_ready(ro_rr), .mem_read_data(ro_rd),
    .mem_write_valid(ro_wv), .mem_write_address(ro_wa), .mem_write_data(ro_wd),
    .mem_write_ready(ro_wr),
    .load_valid(ro_load_valid), .load_address(ro_load_address), .load_data(ro_load_data)
  );

  typedef struct { int ch; int kind; logic [AW-1:0] addr; logic [DW-1:0] data; int acc; } ev_t;
  typedef struct { int ch; bit is_wr; logic [DW-1:0] data; int cyc; } exp_t;

  ev_t           pend [$];
  exp_t          expq [$];
  logic [DW-1:0] ref_mem [int];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (int'(a) >= DEPTH) return '0;
    if (!ref_mem.exists(int'(a))) return '0;
    return ref_mem[int'(a)];
  endfunction

  function automatic void ref_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (int'(a) < DEPTH) ref_mem[int'(a)] = d;
  endfunction

  task automatic check_resp(input int c, input bit is_wr, input logic [DW-1:0] d);
    int idx = -1;
    for (int i = 0; i < expq.size(); i++)
      if (idx < 0 && expq[i].ch == c && expq[i].is_wr == is_wr) idx = i;
    if (idx < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_%s_ready ch%0d: got pulse at cycle %0d, required none",
               is_wr ? "wr" : "rd", c, cyc);
    end else begin
      chk($sformatf("%s_latency_ch%0d", is_wr ? "wr" : "rd", c), 64'(cyc), 64'(expq[idx].cyc));
      if (!is_wr) chk($sformatf("rd_data_ch%0d", c), 64'(d), 64'(expq[idx].data));
      expq.delete(idx);
    end
  endtask

  // Reference model for the edge just passed (reads see old data, then loads, then writes
  // in ascending channel order), followed by the output monitor.
  always @(negedge clk) begin
    for (int i = 0; i < pend.size(); i++)
      if (pend[i].acc == cyc && pend[i].kind == 0)
        expq.push_back('{pend[i].ch, 1'b0, ref_rd(pend[i].addr), cyc});
    for (int i = 0; i < pend.size(); i++)
      if (pend[i].acc == cyc && pend[i].kind == 2) ref_wr(pend[i].addr, pend[i].data);
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < pend.size(); i++)
        if (pend[i].acc == cyc && pend[i].kind == 1 && pend[i].ch == c) begin
          ref_wr(pend[i].addr, pend[i].data);
          expq.push_back('{c, 1'b1, '0, cyc});
        end
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].acc == cyc) pend.delete(i);

    for (int c = 0; c < NC; c++) begin
      if (rr_bus[c]) check_resp(c, 1'b0, rd_bus[c*DW +: DW]);
      if (wr_bus[c]) check_resp(c, 1'b1, '0);
    end
    for (int i = expq.size() - 1; i >= 0; i--)
      if (expq[i].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_%s_ready ch%0d: got none, required pulse at cycle %0d",
                 expq[i].is_wr ? "wr" : "rd", expq[i].ch, expq[i].cyc);
        expq.delete(i);
      end
  end

  // mode: 0 read, 1 write, 2 read+write together (read must win)
  task automatic do_req(input int ch, input int mode, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int extra);
    int c;
    @(negedge clk);
    c = cyc;
    if (mode != 1) begin rv[ch] = 1'b1; ra[ch] = a; end
    if (mode != 0) begin wv[ch] = 1'b1; wa[ch] = a; wd[ch] = d; end
    pend.push_back('{ch, (mode == 1) ? 1 : 0, a, d, c + 1 + LAT});
    for (int k = 0; k < LAT + 2 + extra; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ra[ch] = AW'($urandom);
        wa[ch] = AW'($urandom);
        wd[ch] = $urandom;
      end
    end
    rv[ch] = 1'b0;
    wv[ch] = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    load_valid = 1'b1; load_address = a; load_data = d;
    pend.push_back('{0, 2, a, d, cyc + 1});
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic rand_chan(input int ch);
    for (int k = 0; k < 30; k++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 9) == 0) ? AW'(DEPTH + int'($urandom_range(0, 4)))
                                      : AW'($urandom_range(0, 31));
      do_req(ch, int'($urandom_range(0, 2)), a, $urandom, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int pulses;
    reset = 1'b1;
    for (int i = 0; i < NC; i++) begin
      rv[i] = 1'b0; wv[i] = 1'b0; ra[i] = '0; wa[i] = '0; wd[i] = '0;
    end
    load_valid = 1'b0; load_address = '0; load_data = '0;
    ro_rv = '0; ro_wv = '0; ro_ra = '0; ro_wa = '0; ro_wd = '0;
    ro_load_valid = 1'b0; ro_load_address = '0; ro_load_data = '0;
    #1 reset = 1'b0;
    #1;
    chk("reset_rd_ready", 64'(rr_bus), 64'(0));
    chk("reset_wr_ready", 64'(wr_bus), 64'(0));
    chk("reset_rd_data", 64'(rd_bus), 64'(0));
    chk("reset_ro_ready", 64'({ro_rr, ro_wr}), 64'(0));
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    for (int a = 0; a < 32; a++) do_load(AW'(a), $urandom);
    do_load(16'd5, 32'hDEAD_BEEF);
    do_load(16'd4, 32'h1);
    do_load(16'd7, 32'h55);

    // latency/pulse shape, write-then-read, held valid past the pulse
    do_req(0, 0, 16'd5, '0, 0);
    do_req(1, 1, 16'd9, 32'h1234_5678, 0);
    do_req(1, 0, 16'd9, '0, 0);
    do_req(0, 0, 16'd5, '0, 3);

    // same-edge conflicts
    fork
      do_req(0, 1, 16'd3, 32'hA, 0);
      do_req(1, 1, 16'd3, 32'hB, 1);
    join
    do_req(0, 0, 16'd3, '0, 0);
    fork
      do_req(0, 0, 16'd4, '0, 0);
      do_req(1, 1, 16'd4, 32'h2, 0);
    join
    do_req(1, 0, 16'd4, '0, 0);
    fork
      do_req(0, 1, 16'd10, 32'h00C0_FFEE, 0);
      begin repeat (LAT) @(negedge clk); do_load(16'd10, 32'h0BAD); end
    join
    do_req(1, 0, 16'd10, '0, 0);

    // out of range: read 0, write dropped (no alias onto address 1)
    do_req(0, 0, AW'(DEPTH + 1), '0, 0);
    do_req(1, 1, AW'(DEPTH + 1), 32'hFFFF_FFFF, 0);
    do_req(0, 0, 16'd1, '0, 0);
    do_req(1, 0, AW'(DEPTH + 1), '0, 0);

    // reset while a read pulse is up and a write to 7 is in BUSY
    @(negedge clk);
    c = cyc;
    rv[0] = 1'b1; ra[0] = 16'd5;
    pend.push_back('{0, 0, 16'd5, '0, c + 1 + LAT});
    @(negedge clk);
    wv[1] = 1'b1; wa[1] = 16'd7; wd[1] = 32'h99;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_rd_ready", 64'(rr_bus), 64'(0));
    chk("rst_async_wr_ready", 64'(wr_bus), 64'(0));
    chk("rst_async_rd_data", 64'(rd_bus), 64'(0));
    rv[0] = 1'b0; wv[1] = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    do_req(0, 0, 16'd7, '0, 0);

    // request held across reset is served once, as a new request
    @(negedge clk);
    rv[1] = 1'b1; ra[1] = 16'd7;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_busy_rd_ready", 64'(rr_bus), 64'(0));
    @(negedge clk);
    #2 reset = 1'b1;
    c = cyc;
    pend.push_back('{1, 0, 16'd7, '0, c + 1 + LAT});
    repeat (LAT + 2) @(negedge clk);
    rv[1] = 1'b0;

    fork
      rand_chan(0);
      rand_chan(1);
      for (int k = 0; k < 10; k++) begin
        repeat ($urandom_range(5, 20)) @(negedge clk);
        do_load(AW'($urandom_range(0, 31)), $urandom);
      end
    join

    // read-only instance: writes never acknowledged, reads still served
    @(negedge clk);
    ro_load_valid = 1'b1; ro_load_address = 16'd2; ro_load_data = 32'hCAFE;
    @(negedge clk);
    ro_load_valid = 1'b0;
    ro_wv[0] = 1'b1; ro_wa[AW-1:0] = 16'd2; ro_wd[DW-1:0] = 32'h1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ro_wr[0]) pulses++;
    end
    chk("ro_write_ready_pulses", 64'(pulses), 64'(0));
    ro_wv[0] = 1'b0;
    @(negedge clk);
    ro_rv[0] = 1'b1; ro_ra[AW-1:0] = 16'd2;
    @(negedge clk);
    chk("ro_rd_ready_early", 64'(ro_rr[0]), 64'(0));
    @(negedge clk);
    chk("ro_rd_ready", 64'(ro_rr[0]), 64'(1));
    chk("ro_rd_data", 64'(ro_rd[DW-1:0]), 64'(32'hCAFE));
    ro_rv[0] = 1'b0;

    repeat (10) @(negedge clk);
    chk("pending_events_left", 64'(pend.size()), 64'(0));
    chk("expected_left", 64'(expq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
